store_align_unit: RTL and testbench

Store-side counterpart of the writeback load-alignment logic. Accepts a store from the execute stage, converts little-endian register data into the big-endian byte-lane layout used by data memory, and generates byte enables. It then drives a single-outstanding request/acknowledge write transaction to the data bus. It sits between execute and the data-memory port and back-pressures execute while a store is in flight.

---
 rtl/store_align_unit.sv | 141 ++++++++++++++
 tb/tb_store_align_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/store_align_unit.sv
// Purpose: align little-endian store data into big-endian memory lanes with byte enables, then run one req/ack write.
// Latency: store accepted at edge N drives mem_req in cycle N+1; ack at edge M gives st_done in cycle M+1.
// Backpressure: st_ready drops while a write is outstanding, except in the ack cycle (back-to-back accept).
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   st_valid / st_ready            store handshake from execute
//   fn3_in, addr_in, rs2_data_in   store size, byte address, little-endian data
//   mem_req / mem_ack              single-outstanding write handshake to the data bus
//   mem_addr, mem_wdata, mem_be    registered word address, lane data, byte enables
//   st_done, st_fault              one-cycle completion / timeout pulses
module store_align_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [2:0]  fn3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] rs2_data_in,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic        st_done,
    output logic        st_fault
);

    typedef enum logic {IDLE, BUSY} state_t;

    // Counter value on which a non-acked request is abandoned.
    localparam logic [7:0] TO_LAST = 8'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam bit         TO_EN   = (TIMEOUT_CYCLES != 0);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        done_d, fault_d;
    logic        accept;
    logic [31:0] wdata_al;
    logic [3:0]  be_al;

    // Lane alignment: byte offset k lands in bits [31-8k:24-8k]; unused lanes stay zero.
    always_comb begin
        wdata_al = '0;
        be_al    = '0;
        case (fn3_in[1:0])
            2'd0: begin
                be_al = 4'b1000 >> addr_in[1:0];
                case (addr_in[1:0])
                    2'd0:    wdata_al[31:24] = rs2_data_in[7:0];
                    2'd1:    wdata_al[23:16] = rs2_data_in[7:0];
                    2'd2:    wdata_al[15:8]  = rs2_data_in[7:0];
                    default: wdata_al[7:0]   = rs2_data_in[7:0];
                endcase
            end
            2'd1: begin
                // Halfword: addr_in[0] does not participate.
                if (!addr_in[1]) begin
                    wdata_al[31:16] = {rs2_data_in[7:0], rs2_data_in[15:8]};
                    be_al           = 4'b1100;
                end else begin
                    wdata_al[15:0]  = {rs2_data_in[7:0], rs2_data_in[15:8]};
                    be_al           = 4'b0011;
                end
            end
            default: begin
                wdata_al = {rs2_data_in[7:0], rs2_data_in[15:8],
                            rs2_data_in[23:16], rs2_data_in[31:24]};
                be_al    = 4'b1111;
            end
        endcase
    end

    // Next-state and handshake outputs. mem_ack is only looked at in BUSY,
    // and an ack on the timeout edge takes priority over the timeout.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        fault_d  = 1'b0;
        st_ready = 1'b0;
        mem_req  = 1'b0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                st_ready = 1'b1;
                if (st_valid) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    st_ready = 1'b1;
                    done_d   = 1'b1;
                    if (st_valid) begin
                        accept = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (TO_EN && (cnt_q == TO_LAST)) begin
                        state_d = IDLE;
                        fault_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are only loaded on acceptance, so they hold after completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            st_done   <= 1'b0;
            st_fault  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            st_done  <= done_d;
            st_fault <= fault_d;
            if (accept) begin
                mem_addr  <= addr_in[31:2];
                mem_wdata <= wdata_al;
                mem_be    <= be_al;
            end
        end
    end

endmodule

// File: tb/tb_store_align_unit.sv
module tb_store_align_unit;

    logic        clk;
    logic        rst_n;
    logic [2:0]  fn3_in;
    logic [31:0] addr_in;
    logic [31:0] rs2_data_in;

    // Instance A: default timeout
    logic        st_valid, st_ready, mem_req, mem_ack, st_done, st_fault;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;

    // Instance B: short timeout
    logic        st_valid_b, st_ready_b, mem_req_b, mem_ack_b, st_done_b, st_fault_b;
    logic [29:0] mem_addr_b;
    logic [31:0] mem_wdata_b;
    logic [3:0]  mem_be_b;

    int checks;
    int failures;

    store_align_unit dut (
        .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
        .fn3_in(fn3_in), .addr_in(addr_in), .rs2_data_in(rs2_data_in),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .st_done(st_done), .st_fault(st_fault)
    );

    store_align_unit #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst_n(rst_n), .st_valid(st_valid_b), .st_ready(st_ready_b),
        .fn3_in(fn3_in), .addr_in(addr_in), .rs2_data_in(rs2_data_in),
        .mem_req(mem_req_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_be(mem_be_b),
        .mem_ack(mem_ack_b), .st_done(st_done_b), .st_fault(st_fault_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; st_valid = 1'b0; mem_ack = 1'b0; st_valid_b = 1'b0; mem_ack_b = 1'b0;
        fn3_in = 3'd0; addr_in = 32'h0; rs2_data_in = 32'h0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", mem_req); end
        checks++; if (mem_addr !== 30'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", mem_wdata); end
        checks++; if (mem_be !== 4'b0000) begin failures++; $display("FAIL rst_be got=%b exp=0000", mem_be); end
        checks++; if (st_done !== 1'b0 || st_fault !== 1'b0) begin failures++; $display("FAIL rst_pulses got=%b%b exp=00", st_done, st_fault); end
        checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", st_ready); end
        checks++; if (mem_req_b !== 1'b0) begin failures++; $display("FAIL rst_req_b got=%b exp=0", mem_req_b); end
    endtask

    task automatic test_byte();
        st_valid = 1'b1; fn3_in = 3'b000; addr_in = 32'h0000_1001; rs2_data_in = 32'hDEAD_BEEF;
        tick();
        st_valid = 1'b0; mem_ack = 1'b1; addr_in = 32'hFFFF_FFFF; rs2_data_in = 32'h0;
        #1;
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL sb_req got=%b exp=1", mem_req); end
        checks++; if (mem_addr !== 30'h400) begin failures++; $display("FAIL sb_addr got=%h exp=400", mem_addr); end
        checks++; if (mem_wdata !== 32'h00EF_0000) begin failures++; $display("FAIL sb_wdata got=%h exp=00ef0000", mem_wdata); end
        checks++; if (mem_be !== 4'b0100) begin failures++; $display("FAIL sb_be got=%b exp=0100", mem_be); end
        checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL sb_ready_ack got=%b exp=1", st_ready); end
        tick();
        mem_ack = 1'b0;
        checks++; if (st_done !== 1'b1) begin failures++; $display("FAIL sb_done got=%b exp=1", st_done); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL sb_req_drop got=%b exp=0", mem_req); end
        tick();
        checks++; if (st_done !== 1'b0) begin failures++; $display("FAIL sb_done_once got=%b exp=0", st_done); end
    endtask

    task automatic test_half();
        st_valid = 1'b1; fn3_in = 3'b001; addr_in = 32'h0000_1003; rs2_data_in = 32'h1234_ABCD;
        tick();
        st_valid = 1'b0; mem_ack = 1'b1;
        #1;
        checks++; if (mem_wdata !== 32'h0000_CDAB) begin failures++; $display("FAIL sh_wdata got=%h exp=0000cdab", mem_wdata); end
        checks++; if (mem_be !== 4'b0011) begin failures++; $display("FAIL sh_be got=%b exp=0011", mem_be); end
        checks++; if (mem_addr !== 30'h400) begin failures++; $display("FAIL sh_addr got=%h exp=400", mem_addr); end
        tick();
        mem_ack = 1'b0;
        checks++; if (st_done !== 1'b1) begin failures++; $display("FAIL sh_done got=%b exp=1", st_done); end
        tick();
    endtask

    task automatic test_word_delayed();
        st_valid = 1'b1; fn3_in = 3'b010; addr_in = 32'h0000_2002; rs2_data_in = 32'h1122_3344;
        tick();
        st_valid = 1'b0; addr_in = 32'h0000_0000; rs2_data_in = 32'h5555_5555;
        for (int i = 0; i < 6; i++) begin
            mem_ack = (i == 5);
            #1;
            checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL sw_req[%0d] got=%b exp=1", i, mem_req); end
            checks++; if (mem_wdata !== 32'h4433_2211 || mem_be !== 4'b1111 || mem_addr !== 30'h800) begin
                failures++; $display("FAIL sw_bus[%0d] got=%h/%b/%h exp=44332211/1111/800", i, mem_wdata, mem_be, mem_addr); end
            checks++; if (st_ready !== (i == 5)) begin failures++; $display("FAIL sw_ready[%0d] got=%b exp=%b", i, st_ready, (i == 5)); end
            checks++; if (st_done !== 1'b0) begin failures++; $display("FAIL sw_early_done[%0d] got=%b exp=0", i, st_done); end
            tick();
        end
        mem_ack = 1'b0;
        checks++; if (st_done !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL sw_done got=%b req=%b exp=1/0", st_done, mem_req); end
        checks++; if (mem_wdata !== 32'h4433_2211) begin failures++; $display("FAIL sw_hold got=%h exp=44332211", mem_wdata); end
        tick();
        checks++; if (st_done !== 1'b0) begin failures++; $display("FAIL sw_done_once got=%b exp=0", st_done); end
    endtask

    task automatic test_back_to_back();
        st_valid = 1'b1; fn3_in = 3'b000; addr_in = 32'h0; rs2_data_in = 32'h0000_00AA;
        tick();
        addr_in = 32'h3; rs2_data_in = 32'h0000_00BB; mem_ack = 1'b1;
        #1;
        checks++; if (mem_wdata !== 32'hAA00_0000 || mem_be !== 4'b1000) begin failures++; $display("FAIL b2b_first got=%h/%b exp=aa000000/1000", mem_wdata, mem_be); end
        checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", st_ready); end
        tick();
        st_valid = 1'b0;
        checks++; if (mem_req !== 1'b1 || st_done !== 1'b1) begin failures++; $display("FAIL b2b_c2 req=%b done=%b exp=1/1", mem_req, st_done); end
        checks++; if (mem_wdata !== 32'h0000_00BB || mem_be !== 4'b0001) begin failures++; $display("FAIL b2b_second got=%h/%b exp=000000bb/0001", mem_wdata, mem_be); end
        tick();
        mem_ack = 1'b0;
        checks++; if (st_done !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL b2b_c3 done=%b req=%b exp=1/0", st_done, mem_req); end
        tick();
        checks++; if (st_done !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b exp=0", st_done); end
    endtask

    task automatic test_timeout();
        // No ack: request held exactly four cycles, then a fault pulse.
        st_valid_b = 1'b1; fn3_in = 3'b010; addr_in = 32'h0000_0040; rs2_data_in = 32'hCAFE_F00D;
        tick();
        st_valid_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem_req_b !== 1'b1 || st_fault_b !== 1'b0) begin failures++; $display("FAIL to_req[%0d] req=%b fault=%b exp=1/0", i, mem_req_b, st_fault_b); end
            tick();
        end
        checks++; if (mem_req_b !== 1'b0 || st_fault_b !== 1'b1) begin failures++; $display("FAIL to_fire req=%b fault=%b exp=0/1", mem_req_b, st_fault_b); end
        checks++; if (st_ready_b !== 1'b1 || st_done_b !== 1'b0) begin failures++; $display("FAIL to_ready ready=%b done=%b exp=1/0", st_ready_b, st_done_b); end
        tick();
        checks++; if (st_fault_b !== 1'b0) begin failures++; $display("FAIL to_fault_once got=%b exp=0", st_fault_b); end
        // Ack on the edge the timeout would fire: ack wins.
        st_valid_b = 1'b1;
        tick();
        st_valid_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_ack_b = (i == 3);
            tick();
        end
        mem_ack_b = 1'b0;
        checks++; if (st_done_b !== 1'b1 || st_fault_b !== 1'b0) begin failures++; $display("FAIL to_ackwin done=%b fault=%b exp=1/0", st_done_b, st_fault_b); end
        tick();
        checks++; if (st_done_b !== 1'b0 || st_fault_b !== 1'b0 || mem_req_b !== 1'b0) begin
            failures++; $display("FAIL to_ackwin_after done=%b fault=%b req=%b exp=0/0/0", st_done_b, st_fault_b, mem_req_b); end
    endtask

    task automatic test_reset_mid();
        st_valid = 1'b1; fn3_in = 3'b010; addr_in = 32'h0000_3000; rs2_data_in = 32'h0102_0304;
        tick();
        st_valid = 1'b0;
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rm_busy got=%b exp=1", mem_req); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (mem_req !== 1'b0 || mem_be !== 4'b0000) begin failures++; $display("FAIL rm_cleared req=%b be=%b exp=0/0000", mem_req, mem_be); end
        checks++; if (st_done !== 1'b0 || st_fault !== 1'b0) begin failures++; $display("FAIL rm_pulse0 done=%b fault=%b exp=0/0", st_done, st_fault); end
        st_valid = 1'b1; fn3_in = 3'b000; addr_in = 32'h0000_0002; rs2_data_in = 32'h0000_005A;
        tick();
        st_valid = 1'b0; mem_ack = 1'b1;
        checks++; if (st_done !== 1'b0 || st_fault !== 1'b0) begin failures++; $display("FAIL rm_pulse1 done=%b fault=%b exp=0/0", st_done, st_fault); end
        checks++; if (mem_req !== 1'b1 || mem_wdata !== 32'h0000_5A00 || mem_be !== 4'b0010 || mem_addr !== 30'h0) begin
            failures++; $display("FAIL rm_new req=%b bus=%h/%b/%h exp=1/00005a00/0010/0", mem_req, mem_wdata, mem_be, mem_addr); end
        tick();
        mem_ack = 1'b0;
        checks++; if (st_done !== 1'b1) begin failures++; $display("FAIL rm_done got=%b exp=1", st_done); end
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_byte();
        test_half();
        test_word_delayed();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
